// File: rtl/wrr_arbiter_reg_pkg.sv
// Shared datapath types for the page-access-counter request path.
// mem_request_t is the payload carried from the channel queues into the counter pipeline.
package ctrl_signal_types;

  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  op;
    logic [5:0]  tag;
  } mem_request_t;

endpackage

// File: rtl/wrr_arbiter_reg_priority_arbiter.sv
// Fixed-priority pick: reports the lowest-index set bit of req.
// Combinational; used once on the masked request vector and once on the full vector.
module priority_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set index is the last assignment to win.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end else begin
        any = any;
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter_reg.sv
// Weighted round-robin arbiter with per-port burst credits and a registered
// valid/ready output stage whose payload always belongs to out_port.
module wrr_arbiter_reg
  import ctrl_signal_types::*;
#(
  parameter  int NUM_INPUT_PORT = 4,
  parameter  int WEIGHT_W       = 4,
  localparam int IDX_W          = (NUM_INPUT_PORT > 1) ? $clog2(NUM_INPUT_PORT) : 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_INPUT_PORT-1:0]               in_valid,
  output logic [NUM_INPUT_PORT-1:0]               in_ready,
  input  mem_request_t [NUM_INPUT_PORT-1:0]       in_request,
  input  logic [NUM_INPUT_PORT-1:0][WEIGHT_W-1:0] cfg_weight,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output mem_request_t                            out_request,
  output logic [IDX_W-1:0]                        out_port,
  output logic [IDX_W-1:0]                        owner
);

  logic [WEIGHT_W-1:0]       credit_r;
  logic                      load_s;
  logic [NUM_INPUT_PORT-1:0] mask_s;
  logic                      masked_any_s;
  logic [IDX_W-1:0]          masked_idx_s;
  logic                      full_any_s;
  logic [IDX_W-1:0]          full_idx_s;
  logic                      grant_s;
  logic                      hold_s;
  logic [IDX_W-1:0]          grant_idx_s;
  logic [WEIGHT_W-1:0]       weight_sel_s;
  logic [WEIGHT_W-1:0]       reload_s;

  assign load_s = ~out_valid | out_ready;

  // Ports strictly above the current owner are eligible for the masked pick.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < NUM_INPUT_PORT; i++) begin
      mask_s[i] = (IDX_W'(i) > owner);
    end
  end

  priority_arbiter #(.N(NUM_INPUT_PORT), .IDX_W(IDX_W)) u_masked_pick (
    .req (in_valid & mask_s),
    .any (masked_any_s),
    .idx (masked_idx_s)
  );

  priority_arbiter #(.N(NUM_INPUT_PORT), .IDX_W(IDX_W)) u_full_pick (
    .req (in_valid),
    .any (full_any_s),
    .idx (full_idx_s)
  );

  // Grant selection; reset gates it so in_ready drops with the asynchronous reset.
  always_comb begin
    grant_s     = 1'b0;
    hold_s      = 1'b0;
    grant_idx_s = '0;
    if (reset || !load_s) begin
      grant_s     = 1'b0;
      hold_s      = 1'b0;
      grant_idx_s = '0;
    end else if ((credit_r != '0) && in_valid[owner]) begin
      grant_s     = 1'b1;
      hold_s      = 1'b1;
      grant_idx_s = owner;
    end else if (masked_any_s) begin
      grant_s     = 1'b1;
      grant_idx_s = masked_idx_s;
    end else if (full_any_s) begin
      grant_s     = 1'b1;
      grant_idx_s = full_idx_s;
    end else begin
      grant_s     = 1'b0;
      grant_idx_s = '0;
    end
  end

  // The winning beat consumes one credit, so a weight of w reloads w-1; weight 0 acts as 1.
  always_comb begin
    weight_sel_s = cfg_weight[grant_idx_s];
    if (weight_sel_s == '0) begin
      reload_s = '0;
    end else begin
      reload_s = weight_sel_s - WEIGHT_W'(1);
    end
  end

  // One-hot accept strobe mirrors the grant.
  always_comb begin
    in_ready = '0;
    if (grant_s) begin
      in_ready[grant_idx_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Turn/credit state and the output register advance only when the stage can load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_request <= '0;
      out_port    <= '0;
      owner       <= IDX_W'(NUM_INPUT_PORT - 1);
      credit_r    <= '0;
    end else if (load_s) begin
      if (grant_s) begin
        out_valid   <= 1'b1;
        out_request <= in_request[grant_idx_s];
        out_port    <= grant_idx_s;
        if (hold_s) begin
          credit_r <= credit_r - WEIGHT_W'(1);
        end else begin
          owner    <= grant_idx_s;
          credit_r <= reload_s;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wrr_arbiter_reg.sv
// Directed bench for wrr_arbiter_reg: rotation, weights, stalls, forfeit and async reset.
module tb_wrr_arbiter_reg;
  import ctrl_signal_types::*;

  logic               clk = 1'b0;
  logic               reset;
  logic [3:0]         in_valid;
  logic [3:0]         in_ready;
  mem_request_t [3:0] in_request;
  logic [3:0][3:0]    cfg_weight;
  logic               out_valid;
  logic               out_ready;
  mem_request_t       out_request;
  logic [1:0]         out_port;
  logic [1:0]         owner;

  int errors = 0;
  int checks = 0;

  wrr_arbiter_reg #(.NUM_INPUT_PORT(4), .WEIGHT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_request  (in_request),
    .cfg_weight  (cfg_weight),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_request (out_request),
    .out_port    (out_port),
    .owner       (owner)
  );

  always #5 clk = ~clk;

  function automatic mem_request_t pay(input int p);
    mem_request_t r;
    r.addr = 16'hA000 | 16'(p * 273);
    r.op   = 2'(p);
    r.tag  = 6'(p + 5);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] w0, input logic [3:0] w1,
                          input logic [3:0] w2, input logic [3:0] w3);
    reset     = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    cfg_weight[0] = w0;
    cfg_weight[1] = w1;
    cfg_weight[2] = w2;
    cfg_weight[3] = w3;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (out_valid !== 1'b0 || out_port !== 2'd0 || out_request !== '0 ||
        owner !== 2'd3 || in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b out_port=%0d out_request=%h owner=%0d in_ready=%b, expected 0 0 0 3 0000",
               out_valid, out_port, out_request, owner, in_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset(4'd1, 4'd1, 4'd1, 4'd1);
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rr_first_ready: in_ready=%b expected 0001", in_ready);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_port !== 2'(exp[k]) || out_request !== pay(exp[k])) begin
        errors++;
        $display("FAIL rr_beat%0d: valid=%b port=%0d req=%h, expected 1 %0d %h",
                 k, out_valid, out_port, out_request, exp[k], pay(exp[k]));
      end
    end
  endtask

  task automatic test_weights();
    int exp[14] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1, 2, 2, 3};
    do_reset(4'd3, 4'd1, 4'd2, 4'd1);
    in_valid = 4'b1111;
    for (int k = 0; k < 14; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_port !== 2'(exp[k]) || out_request !== pay(exp[k]) ||
          owner !== 2'(exp[k])) begin
        errors++;
        $display("FAIL wt_beat%0d: valid=%b port=%0d owner=%0d req=%h, expected port/owner %0d req %h",
                 k, out_valid, out_port, owner, out_request, exp[k], pay(exp[k]));
      end
    end
  endtask

  task automatic test_zero_weight();
    int exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset(4'd1, 4'd1, 4'd0, 4'd1);
    in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_port !== 2'(exp[k]) || out_request !== pay(exp[k])) begin
        errors++;
        $display("FAIL zw_beat%0d: valid=%b port=%0d req=%h, expected 1 %0d %h",
                 k, out_valid, out_port, out_request, exp[k], pay(exp[k]));
      end
    end
  endtask

  task automatic test_stall();
    int exp[4] = '{0, 1, 2, 3};
    do_reset(4'd3, 4'd1, 4'd1, 4'd1);
    in_valid = 4'b1111;
    step();
    step();
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_port !== 2'd0 ||
          out_request !== pay(0) || owner !== 2'd0) begin
        errors++;
        $display("FAIL stall_cyc%0d: in_ready=%b valid=%b port=%0d owner=%0d req=%h, expected 0000 1 0 0 %h",
                 k, in_ready, out_valid, out_port, owner, out_request, pay(0));
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL stall_release_ready: in_ready=%b expected 0001", in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_port !== 2'(exp[k]) || out_request !== pay(exp[k])) begin
        errors++;
        $display("FAIL stall_resume%0d: valid=%b port=%0d req=%h, expected 1 %0d %h",
                 k, out_valid, out_port, out_request, exp[k], pay(exp[k]));
      end
    end
  endtask

  task automatic test_forfeit();
    int exp[5] = '{1, 1, 1, 1, 3};
    do_reset(4'd1, 4'd4, 4'd1, 4'd1);
    in_valid = 4'b1010;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_port !== 2'd1) begin
        errors++;
        $display("FAIL ff_burst%0d: valid=%b port=%0d, expected 1 1", k, out_valid, out_port);
      end
    end
    in_valid = 4'b1000;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_port !== 2'd3 || owner !== 2'd3 || out_request !== pay(3)) begin
      errors++;
      $display("FAIL ff_switch: valid=%b port=%0d owner=%0d req=%h, expected 1 3 3 %h",
               out_valid, out_port, owner, out_request, pay(3));
    end
    step();
    in_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_port !== 2'(exp[k]) || out_request !== pay(exp[k])) begin
        errors++;
        $display("FAIL ff_reentry%0d: valid=%b port=%0d req=%h, expected 1 %0d %h",
                 k, out_valid, out_port, out_request, exp[k], pay(exp[k]));
      end
    end
    in_valid = 4'b0000;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_request !== pay(3) || owner !== 2'd3) begin
      errors++;
      $display("FAIL idle_hold: valid=%b req=%h owner=%0d, expected 0 %h 3",
               out_valid, out_request, owner, pay(3));
    end
  endtask

  task automatic test_async_reset();
    int exp[4] = '{0, 0, 0, 1};
    do_reset(4'd3, 4'd1, 4'd1, 4'd1);
    in_valid = 4'b1111;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000 || owner !== 2'd3) begin
      errors++;
      $display("FAIL async_reset: valid=%b in_ready=%b owner=%0d, expected 0 0000 3",
               out_valid, in_ready, owner);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_port !== 2'(exp[k]) || out_request !== pay(exp[k])) begin
        errors++;
        $display("FAIL post_reset%0d: valid=%b port=%0d req=%h, expected 1 %0d %h",
                 k, out_valid, out_port, out_request, exp[k], pay(exp[k]));
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_request[i] = pay(i);
      cfg_weight[i] = 4'd1;
    end
    test_reset();
    test_round_robin();
    test_weights();
    test_zero_weight();
    test_stall();
    test_forfeit();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter_reg.md
Name: wrr_arbiter_reg

Overview:
Parametrised weighted round-robin arbiter for mem_request_t traffic in the page-access-counter datapath. It is the successor to the plain registered round-robin arbiter and adds:
- per-port valid/ready handshakes
- per-port programmable weights (burst credits)
- a registered output stage with valid/ready backpressure, whose payload always matches the granted port.

It sits between the per-channel request queues and the shared counter-update pipeline.

Parameters:
NUM_INPUT_PORT, 4, number of requesting ports (>=1).
WEIGHT_W, 4, width of each per-port weight and of the credit counter.
IDX_W, max(1,$clog2(NUM_INPUT_PORT)), width of the port index (derived; do not override).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  NUM_INPUT_PORT  per-port request valid
in_ready  out  NUM_INPUT_PORT  per-port accept; one-hot or zero
in_request  in  mem_request_t[NUM_INPUT_PORT]  per-port payload
cfg_weight  in  WEIGHT_W[NUM_INPUT_PORT]  beats per turn; 0 is treated as 1
out_valid  out  1  registered output valid
out_ready  in  1  downstream accept
out_request  out  mem_request_t  registered payload
out_port  out  IDX_W  source port of out_request
owner  out  IDX_W  current turn owner (debug/perf)

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: out_valid=0, out_request='0, out_port=0, owner=NUM_INPUT_PORT-1, credit=0, in_ready=0. With owner at the last port, port 0 wins first after reset.
- load = ~out_valid | out_ready. No port is granted while load=0 (full output stage stalled).
- Handshake: in_ready is combinational and equals grant. A transfer on port i occurs when in_valid[i] & in_ready[i]. in_valid must not depend on in_ready.
- Grant selection, only when load=1:
  - Hold case: if credit>0 and in_valid[owner], grant owner and decrement credit.
  - Otherwise rotate: grant the lowest-index valid port strictly above owner (masked pick). If there is none, grant the lowest-index valid port overall (unmasked pick).
  - On rotate: owner <= granted index; credit <= max(cfg_weight[granted],1)-1.
  - A rotate may re-select the same port when it is the only requester; it then gets a fresh credit reload.
- Output register:
  - On a grant: out_request <= in_request[granted], out_port <= granted, out_valid <= 1, all in the same edge.
  - If load=1 and no grant: out_valid <= 0; out_request is held (not cleared).
  - If load=0: all output registers hold.
- Latency: one cycle from grant to out_valid. Full throughput of one beat/cycle while out_ready=1.
- Owner stops requesting mid-burst: remaining credit is forfeited and the arbiter rotates in that cycle.
- cfg_weight changes take effect only at the next credit reload. Weights are never sampled mid-burst.
- No valid inputs: owner and credit hold.
- Stall mid-burst (out_ready=0): credit and owner hold; nothing is consumed.
- Reset asserted mid-operation: the pending output is discarded immediately (async). in_ready drops in the same cycle.
- NUM_INPUT_PORT=1: degenerates to a registered pipe stage; weight is irrelevant.

Decomposition:
- Package ctrl_signal_types: mem_request_t already lives there. Add typedef arb_weight_t logic[WEIGHT_W-1:0] only if shared with the CSR block; otherwise keep WEIGHT_W local.
- Sub-module: reuse priority_arbiter twice (masked and unmasked pick). Credit/owner state and output register stay in this module.

Test Plan:
1. All four ports valid, weights {1,1,1,1}, out_ready=1 -> out_port sequence 0,1,2,3,0,1... one per cycle; out_request payload matches out_port every beat.
2. Weights {3,1,2,1}, all valid -> out_port sequence 0,0,0,1,2,2,3 repeating; credit reloads observed at each owner change.
3. Weight 0 on port 2, all valid -> port 2 granted exactly one beat per round; no hang.
4. out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0 throughout; out_request/out_port/owner/credit stable; first beat after release resumes the burst with no beat lost or duplicated.
5. Port 1 owner with weight 4 drops in_valid after 2 beats while port 3 is valid -> next beat from port 3; port 1 re-entering later receives a fresh 4-beat credit.
6. Assert reset asynchronously while out_valid=1 mid-burst -> out_valid=0 and in_ready=0 immediately; after release, first grant goes to the lowest valid port (port 0 if valid).
